// File: rtl/gesture_motion_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : gesture_motion_sequencer
// Description : Five-channel servo motion sequencer for a robotic hand. It
//               accepts a set of target pulse widths in IDLE, clamps them to
//               the safe range, and then walks every channel toward its
//               target by at most STEP_US once per servo frame. It finishes
//               with a one-cycle done pulse when all channels arrive or the
//               motion is aborted.
// Ports       : clk          - system clock, rising edge
//               reset        - synchronous reset, active-high
//               cmd_valid    - target command present
//               cmd_ready    - high in IDLE, command can be accepted
//               cmd_targets  - 5 x 16-bit target widths in us
//                              (thumb, index, middle, ring, pinky from LSB)
//               cmd_abort    - freeze motion at the current widths
//               width_out    - registered per-channel widths, same packing
//               busy         - high whenever not IDLE
//               done         - one-cycle pulse at motion end or abort
// Revision    : 1.0 - initial release
// ============================================================================
module gesture_motion_sequencer #(
    parameter int FRAME_CYCLES = 1000000,
    parameter int STEP_US      = 10,
    parameter int MIN_US       = 1000,
    parameter int MAX_US       = 2000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [79:0] cmd_targets,
    input  logic        cmd_abort,
    output logic [79:0] width_out,
    output logic        busy,
    output logic        done
);

    localparam int              CNT_W      = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [15:0]     C_MIN      = 16'(MIN_US);
    localparam logic [15:0]     C_MAX      = 16'(MAX_US);
    localparam logic [15:0]     C_STEP     = 16'(STEP_US);
    localparam logic [15:0]     C_RESET_US = 16'd1500;
    localparam int              C_NCH      = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_frame_cnt;
    logic [15:0]      r_width   [C_NCH];
    logic [15:0]      r_target  [C_NCH];
    logic [15:0]      w_clamped [C_NCH];
    logic [15:0]      w_stepped [C_NCH];
    logic [C_NCH-1:0] w_ch_at_target;
    logic             w_all_at_target;
    logic             w_accept;
    logic             w_frame_end;

    // Per-channel clamp of the incoming command and the next-frame width.
    // The distance is formed first so the step can never pass the target.
    for (genvar i = 0; i < C_NCH; i++) begin : g_ch
        logic [15:0] w_cmd;
        logic        w_up;
        logic [15:0] w_diff;
        logic [15:0] w_step;

        assign w_cmd  = cmd_targets[16*i +: 16];
        assign w_clamped[i] = (w_cmd < C_MIN) ? C_MIN :
                              (w_cmd > C_MAX) ? C_MAX : w_cmd;
        assign w_up   = (r_target[i] >= r_width[i]);
        assign w_diff = w_up ? (r_target[i] - r_width[i]) : (r_width[i] - r_target[i]);
        assign w_step = (w_diff < C_STEP) ? w_diff : C_STEP;
        assign w_stepped[i] = w_up ? (r_width[i] + w_step) : (r_width[i] - w_step);
        assign w_ch_at_target[i] = (r_width[i] == r_target[i]);
        assign width_out[16*i +: 16] = r_width[i];
    end

    assign w_all_at_target = &w_ch_at_target;
    assign w_accept        = (r_state == IDLE) && cmd_valid;
    assign w_frame_end     = (r_frame_cnt == C_CNT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and status outputs
    always_comb begin
        w_next_state = r_state;
        cmd_ready    = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    w_next_state = MOVE;
                end
            end
            MOVE: begin
                // Arrival is checked every cycle, so a command that asks for
                // the current widths completes without waiting for a frame.
                if (cmd_abort || w_all_at_target) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                done         = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Targets, widths and frame timing
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_cnt <= '0;
            for (int i = 0; i < C_NCH; i++) begin
                r_width[i]  <= C_RESET_US;
                r_target[i] <= C_RESET_US;
            end
        end else if (w_accept) begin
            r_frame_cnt <= '0;
            for (int i = 0; i < C_NCH; i++) begin
                r_target[i] <= w_clamped[i];
            end
        end else if (r_state == MOVE) begin
            if (cmd_abort) begin
                // Abort beats a coincident frame tick: widths stay put.
                for (int i = 0; i < C_NCH; i++) begin
                    r_target[i] <= r_width[i];
                end
            end else if (w_frame_end) begin
                r_frame_cnt <= '0;
                for (int i = 0; i < C_NCH; i++) begin
                    r_width[i] <= w_stepped[i];
                end
            end else begin
                r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire
